led_chaser_ng: RTL and testbench

Parametrised pattern chaser: a WIDTH-bit register loaded with a seed pattern and advanced by rotate-left, rotate-right, bounce or hold moves, at either the full clock rate or a 2^PRESCALE_BITS prescaled rate. It is the synchronous, generalised successor of the fixed 6-bit one-hot chaser with its ripple-counter divider. All state lives in the single clock domain. Prescaling uses a clock-enable, not derived clocks. It drives the user-module outputs (LED bar / seven-segment segments) directly.

---
 rtl/led_chaser_ng.sv | 106 ++++++++++
 tb/tb_led_chaser_ng.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_chaser_ng.sv
// Pattern chaser: a WIDTH-bit register advanced by rotate, bounce or hold moves,
// either every cycle or once per 2^PRESCALE_BITS cycles via a clock-enable prescaler.
module led_chaser_ng #(
  parameter int                 WIDTH         = 6,
  parameter int                 PRESCALE_BITS = 11,
  parameter logic [WIDTH-1:0]   SEED          = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             fast,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] pattern,
  output logic             dir,
  output logic             step
);

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'b00,
    MODE_ROTR   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;

  logic [PRESCALE_BITS-1:0] count;
  logic                     tick;
  logic                     adv;
  logic [WIDTH-1:0]         rotl;
  logic [WIDTH-1:0]         rotr;
  mode_t                    mode_sel;

  assign mode_sel = mode_t'(mode);
  assign tick     = fast | (count == {PRESCALE_BITS{1'b1}});
  assign adv      = run & tick;
  assign rotl     = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
  assign rotr     = {pattern[0], pattern[WIDTH-1:1]};

  // Prescaler is held clear while stopped or bypassed, so re-entering slow
  // mode always yields a full period before the next advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!run || fast) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= 1'b0;
    end else begin
      step <= adv;
    end
  end

  // Bounce turns around when the leading end bit is already set, so each end
  // bit is shown for exactly one advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern <= SEED;
      dir     <= 1'b0;
    end else if (!run) begin
      pattern <= SEED;
      dir     <= 1'b0;
    end else if (adv) begin
      unique case (mode_sel)
        MODE_ROTL: begin
          pattern <= rotl;
          dir     <= 1'b0;
        end
        MODE_ROTR: begin
          pattern <= rotr;
          dir     <= 1'b1;
        end
        MODE_BOUNCE: begin
          if (!dir) begin
            if (pattern[WIDTH-1]) begin
              pattern <= rotr;
              dir     <= 1'b1;
            end else begin
              pattern <= rotl;
            end
          end else begin
            if (pattern[0]) begin
              pattern <= rotl;
              dir     <= 1'b0;
            end else begin
              pattern <= rotr;
            end
          end
        end
        MODE_HOLD: begin
          pattern <= pattern;
          dir     <= dir;
        end
        default: begin
          pattern <= pattern;
          dir     <= dir;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_chaser_ng.sv
// Self-checking bench for led_chaser_ng: two instances (default and arbitrary
// seed) compared every cycle against an arithmetic model, plus literal checks.
module tb_led_chaser_ng;

  localparam int W      = 6;
  localparam int PB     = 3;
  localparam int PERIOD = 8;
  localparam int FULL   = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b0;
  logic         fast = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] pat_a, pat_b;
  logic         dir_a, dir_b, step_a, step_b;

  int errors = 0;
  int checks = 0;

  int m_pat [2];
  int m_dir [2];
  int m_step;
  int m_cnt;

  led_chaser_ng #(.WIDTH(W), .PRESCALE_BITS(PB)) dut_a (
    .clk(clk), .rst(rst), .run(run), .fast(fast), .mode(mode),
    .pattern(pat_a), .dir(dir_a), .step(step_a)
  );

  led_chaser_ng #(.WIDTH(W), .PRESCALE_BITS(PB), .SEED(6'b101101)) dut_b (
    .clk(clk), .rst(rst), .run(run), .fast(fast), .mode(mode),
    .pattern(pat_b), .dir(dir_b), .step(step_b)
  );

  always #5 clk = ~clk;

  function automatic int seed_of(input int k);
    return (k == 0) ? 32 : 45;
  endfunction

  function automatic int rot_left(input int p);
    return ((p * 2) % FULL) + (p / (FULL / 2));
  endfunction

  function automatic int rot_right(input int p);
    return (p / 2) + (p % 2) * (FULL / 2);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pat[k] = seed_of(k);
      m_dir[k] = 0;
    end
    m_step = 0;
    m_cnt  = 0;
  endtask

  task automatic model_edge();
    bit tick, adv;
    tick   = fast || (m_cnt == PERIOD - 1);
    adv    = run && tick;
    m_step = adv;
    m_cnt  = (!run || fast) ? 0 : (m_cnt + 1) % PERIOD;
    for (int k = 0; k < 2; k++) begin
      if (!run) begin
        m_pat[k] = seed_of(k);
        m_dir[k] = 0;
      end else if (adv) begin
        case (mode)
          2'd0: begin m_pat[k] = rot_left(m_pat[k]);  m_dir[k] = 0; end
          2'd1: begin m_pat[k] = rot_right(m_pat[k]); m_dir[k] = 1; end
          2'd2: begin
            if (m_dir[k] == 0) begin
              if (m_pat[k] >= FULL / 2) begin
                m_pat[k] = rot_right(m_pat[k]); m_dir[k] = 1;
              end else begin
                m_pat[k] = rot_left(m_pat[k]);
              end
            end else begin
              if (m_pat[k] % 2 == 1) begin
                m_pat[k] = rot_left(m_pat[k]); m_dir[k] = 0;
              end else begin
                m_pat[k] = rot_right(m_pat[k]);
              end
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit f, input logic [1:0] m);
    @(negedge clk);
    #1;
    run  = r;
    fast = f;
    mode = m;
  endtask

  // Reference model follows the async reset and every clock edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_edge();
    end
  end

  // Outputs are compared against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model_pattern_a", int'(pat_a), m_pat[0]);
      checkOutput("model_dir_a",     int'(dir_a), m_dir[0]);
      checkOutput("model_step_a",    int'(step_a), m_step);
      checkOutput("model_pattern_b", int'(pat_b), m_pat[1]);
      checkOutput("model_dir_b",     int'(dir_b), m_dir[1]);
      checkOutput("model_step_b",    int'(step_b), m_step);
    end
  end

  initial begin
    int bounce_pat [11] = '{6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001,
                            6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000,
                            6'b010000};
    int bounce_dir [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};

    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("reset_pattern", int'(pat_a), 6'b100000);
    checkOutput("reset_dir",     int'(dir_a), 0);
    checkOutput("reset_step",    int'(step_a), 0);
    checkOutput("reset_seed_b",  int'(pat_b), 6'b101101);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fast rotate left from seed
    applyStimulus(1, 1, 2'b00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("rotl_pattern", int'(pat_a), 1 << i);
      checkOutput("rotl_step",    int'(step_a), 1);
      checkOutput("rotl_dir",     int'(dir_a), 0);
    end

    // Slow rotate right: first advance exactly 8 edges after run rises
    applyStimulus(0, 1, 2'b00);
    applyStimulus(1, 0, 2'b01);
    for (int e = 1; e <= 17; e++) begin
      @(posedge clk);
      #1;
      if (e == 7) begin
        checkOutput("slow_before_pattern", int'(pat_a), 6'b100000);
        checkOutput("slow_before_step",    int'(step_a), 0);
      end
      if (e == 8) begin
        checkOutput("slow_adv_pattern", int'(pat_a), 6'b010000);
        checkOutput("slow_adv_step",    int'(step_a), 1);
        checkOutput("slow_adv_dir",     int'(dir_a), 1);
      end
      if (e == 9)  checkOutput("slow_step_drop", int'(step_a), 0);
      if (e == 16) checkOutput("slow_second_adv", int'(pat_a), 6'b001000);
    end

    // Fast bounce from one-hot seed
    applyStimulus(0, 1, 2'b10);
    applyStimulus(1, 1, 2'b10);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      checkOutput("bounce_pattern", int'(pat_a), bounce_pat[i]);
      checkOutput("bounce_dir",     int'(dir_a), bounce_dir[i]);
    end

    // Hold in slow mode, then switch to rotate left mid-count
    applyStimulus(0, 0, 2'b11);
    applyStimulus(1, 0, 2'b11);
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk);
      #1;
      if (e == 19) mode = 2'b00;
      if (e < 24) begin
        checkOutput("hold_pattern", int'(pat_a), 6'b100000);
        checkOutput("hold_step",    int'(step_a), (e % 8 == 0) ? 1 : 0);
      end else begin
        checkOutput("hold_to_rotl_pattern", int'(pat_a), 6'b000001);
        checkOutput("hold_to_rotl_step",    int'(step_a), 1);
      end
    end

    // Drop run for one cycle mid-sequence
    applyStimulus(1, 1, 2'b01);
    repeat (3) @(negedge clk);
    applyStimulus(0, 1, 2'b01);
    @(negedge clk);
    checkOutput("drop_run_pattern", int'(pat_a), 6'b100000);
    checkOutput("drop_run_dir",     int'(dir_a), 0);
    #1;
    run  = 1'b1;
    fast = 1'b0;
    mode = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e == 7) checkOutput("restart_before", int'(pat_a), 6'b100000);
      if (e == 8) checkOutput("restart_adv",    int'(pat_a), 6'b000001);
    end

    // Randomised phase checked by the model process
    for (int n = 0; n < 60; n++) begin
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                    2'($urandom_range(0, 3)));
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end

    // Asynchronous reset between edges during bounce
    applyStimulus(1, 1, 2'b10);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_rst_pattern", int'(pat_a), 6'b100000);
    checkOutput("async_rst_dir",     int'(dir_a), 0);
    checkOutput("async_rst_step",    int'(step_a), 0);
    checkOutput("async_rst_seed_b",  int'(pat_b), 6'b101101);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
